// File: rtl/fetch_pkg.sv
// Shared types and constants for the bytecode fetch unit and its byte FIFO.
package fetch_pkg;

    // The encoding puts mem_start in state[0], so the request strobe comes straight from a flop.
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        REQ     = 2'b01,
        DISCARD = 2'b11
    } fetch_state_t;

    localparam int WORD_BYTES = 4;
    localparam int MAX_TAKE   = 4;
    localparam int LANE_CNT_W = 3;  // holds 0..MAX_TAKE

    // Bytes of a fetched word that remain once the first `offset` bytes are dropped.
    function automatic logic [LANE_CNT_W-1:0] bytes_from_offset(input logic [1:0] offset);
        return LANE_CNT_W'(WORD_BYTES) - LANE_CNT_W'(offset);
    endfunction

endpackage

// File: rtl/fetch_byte_fifo.sv
// Byte FIFO with up to four pushes and four pops per cycle, flush, and a
// big-endian four-byte head window decoded straight from the storage registers.
module fetch_byte_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  pc_reset,
    input  logic                  flush,
    input  logic [LANE_CNT_W-1:0] push_count,
    input  logic [31:0]           push_data,
    input  logic [LANE_CNT_W-1:0] pop_count,
    input  logic [LANE_CNT_W-1:0] space_need,
    output logic                  space_ok,
    output logic [31:0]           head_data,
    output logic [LANE_CNT_W-1:0] head_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [7:0]       storage [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [OCC_W-1:0] occ;

    assign wr_ptr = rd_ptr + PTR_W'(occ);

    // NOTE: only pointers and occupancy are reset; storage is not, because no byte
    // outside the occupied range is ever presented.
    always_ff @(posedge clk or negedge pc_reset) begin
        if (!pc_reset) begin
            rd_ptr <= '0;
            occ    <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            rd_ptr <= rd_ptr + PTR_W'(pop_count);
            occ    <= occ + OCC_W'(push_count) - OCC_W'(pop_count);
        end
    end

    // push_data carries the first byte to enqueue in [7:0].
    always_ff @(posedge clk) begin
        if (!flush) begin
            for (int i = 0; i < WORD_BYTES; i++) begin
                if (LANE_CNT_W'(i) < push_count)
                    storage[wr_ptr + PTR_W'(i)] <= push_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        head_data = '0;
        for (int k = 0; k < MAX_TAKE; k++) begin
            if (OCC_W'(k) < occ)
                head_data[31 - 8*k -: 8] = storage[rd_ptr + PTR_W'(k)];
        end
        head_count = (occ >= OCC_W'(MAX_TAKE)) ? LANE_CNT_W'(MAX_TAKE) : LANE_CNT_W'(occ);
        space_ok   = (OCC_W'(DEPTH) - occ) >= OCC_W'(space_need);
    end

endmodule

// File: rtl/bytecode_fetch_unit.sv
// Bytecode fetch unit: word requests to code memory feed a byte prefetch FIFO that
// presents up to four upcoming bytes. Define FETCH_STATS_EN for word/redirect counters.
module bytecode_fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 8,
    parameter int RAM_SIZE      = 256,
    parameter int FIFO_DEPTH    = 8
) (
    input  logic                     clk,
    input  logic                     pc_reset,
    input  logic [ADDRESS_WIDTH-1:0] pc_reset_value,
    input  logic                     enable,
    input  logic                     redirect,
    input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
    output logic                     mem_start,
    output logic [ADDRESS_WIDTH-3:0] mem_address,
    input  logic [31:0]              mem_data,
    input  logic                     mem_ready,
    output logic [31:0]              out_data,
    output logic [2:0]               out_count,
    output logic [ADDRESS_WIDTH-1:0] out_pc,
`ifdef FETCH_STATS_EN
    output logic [15:0]              stat_words,
    output logic [15:0]              stat_redirects,
`endif
    input  logic                     take,
    input  logic [2:0]               take_len,
    output logic                     take_err
);

    localparam int WAW = ADDRESS_WIDTH - 2;

    if (RAM_SIZE > (1 << ADDRESS_WIDTH)) begin : g_ram_size_check
        $error("RAM_SIZE does not fit the pc address space");
    end
    if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
        $error("FIFO_DEPTH must be a power of two and at least 4");
    end

    fetch_state_t             state;
    fetch_state_t             state_next;
    logic [ADDRESS_WIDTH-1:0] fetch_pc;
    logic                     accept;
    logic                     issue;
    logic                     space_ok;
    logic                     take_ok;
    logic                     take_bad;
    logic [LANE_CNT_W-1:0]    space_need;
    logic [LANE_CNT_W-1:0]    push_count;
    logic [LANE_CNT_W-1:0]    pop_count;
    logic [31:0]              push_data;

    assign accept     = mem_start & mem_ready;
    assign space_need = bytes_from_offset(fetch_pc[1:0]);
    // A redirect flushes the FIFO, so the restart request never waits for space.
    assign issue      = enable && (redirect || space_ok);
    assign take_ok    = take && (take_len != '0) && (take_len <= LANE_CNT_W'(MAX_TAKE))
                        && (take_len <= out_count);
    assign take_bad   = take && !redirect && !take_ok;

    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge pc_reset) begin
        if (!pc_reset) state <= IDLE;
        else           state <= state_next;
    end

    // NOTE: every comb output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (issue) state_next = REQ;
            REQ:     if (accept) state_next = IDLE;
                     else if (redirect) state_next = DISCARD;
            DISCARD: if (accept) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_start  = state[0];
        push_data  = mem_data >> {fetch_pc[1:0], 3'b000};
        push_count = '0;
        pop_count  = '0;
        if (state == REQ && accept && !redirect) push_count = space_need;
        if (take_ok && !redirect)                 pop_count  = take_len;
    end

    always_ff @(posedge clk or negedge pc_reset) begin
        if (!pc_reset) begin
            fetch_pc    <= pc_reset_value;
            out_pc      <= pc_reset_value;
            mem_address <= pc_reset_value[ADDRESS_WIDTH-1:2];
            take_err    <= 1'b0;
        end else begin
            take_err <= take_bad;
            if (redirect) begin
                fetch_pc <= redirect_pc;
                out_pc   <= redirect_pc;
            end else begin
                if (state == REQ && accept)
                    fetch_pc <= {fetch_pc[ADDRESS_WIDTH-1:2] + WAW'(1), 2'b00};
                if (pop_count != '0)
                    out_pc <= out_pc + ADDRESS_WIDTH'(pop_count);
            end
            if (state == IDLE && issue)
                mem_address <= redirect ? redirect_pc[ADDRESS_WIDTH-1:2]
                                        : fetch_pc[ADDRESS_WIDTH-1:2];
        end
    end

`ifdef FETCH_STATS_EN
    always_ff @(posedge clk or negedge pc_reset) begin
        if (!pc_reset) begin
            stat_words     <= '0;
            stat_redirects <= '0;
        end else begin
            if (accept && stat_words != '1)       stat_words     <= stat_words + 16'd1;
            if (redirect && stat_redirects != '1) stat_redirects <= stat_redirects + 16'd1;
        end
    end
`endif

    fetch_byte_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .pc_reset  (pc_reset),
        .flush     (redirect),
        .push_count(push_count),
        .push_data (push_data),
        .pop_count (pop_count),
        .space_need(space_need),
        .space_ok  (space_ok),
        .head_data (out_data),
        .head_count(out_count)
    );

endmodule

// File: tb/tb_bytecode_fetch_unit.sv
// Directed bench for bytecode_fetch_unit with a word-organised code memory model.
module tb_bytecode_fetch_unit;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          pc_reset;
    logic [AW-1:0] pc_reset_value;
    logic          enable;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic          mem_start;
    logic [AW-3:0] mem_address;
    logic [31:0]   mem_data;
    logic          mem_ready;
    logic [31:0]   out_data;
    logic [2:0]    out_count;
    logic [AW-1:0] out_pc;
    logic          take;
    logic [2:0]    take_len;
    logic          take_err;
`ifdef FETCH_STATS_EN
    logic [15:0]   stat_words;
    logic [15:0]   stat_redirects;
`endif

    logic [31:0] code_mem [64];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign mem_data = code_mem[mem_address];

    bytecode_fetch_unit #(
        .ADDRESS_WIDTH(AW),
        .RAM_SIZE     (256),
        .FIFO_DEPTH   (8)
    ) dut (
        .clk           (clk),
        .pc_reset      (pc_reset),
        .pc_reset_value(pc_reset_value),
        .enable        (enable),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .mem_start     (mem_start),
        .mem_address   (mem_address),
        .mem_data      (mem_data),
        .mem_ready     (mem_ready),
        .out_data      (out_data),
        .out_count     (out_count),
        .out_pc        (out_pc),
`ifdef FETCH_STATS_EN
        .stat_words    (stat_words),
        .stat_redirects(stat_redirects),
`endif
        .take          (take),
        .take_len      (take_len),
        .take_err      (take_err)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        code_mem[0] = 32'h4433_2211;
        code_mem[1] = 32'h8877_6655;
        for (int w = 2; w < 64; w++) begin
            for (int b = 0; b < 4; b++) begin
                logic [7:0] addr_byte;
                addr_byte = 8'(4*w + b);
                code_mem[w][8*b +: 8] = addr_byte ^ 8'hA5;
            end
        end

        pc_reset       = 1'b1;
        pc_reset_value = 8'h00;
        enable         = 1'b0;
        redirect       = 1'b0;
        redirect_pc    = 8'h00;
        mem_ready      = 1'b1;
        take           = 1'b0;
        take_len       = 3'd0;
        #1 pc_reset = 1'b0;
        tick(2);
        check("rst_out_count", 32'(out_count), 32'd0);
        check("rst_out_data",  out_data, 32'h0);
        check("rst_mem_start", 32'(mem_start), 32'd0);
        check("rst_take_err",  32'(take_err), 32'd0);
        check("rst_out_pc",    32'(out_pc), 32'h00);

        // Aligned start, memory always ready.
        pc_reset = 1'b1;
        enable   = 1'b1;
        tick(1);
        check("first_req_start", 32'(mem_start), 32'd1);
        check("first_req_addr",  32'(mem_address), 32'h00);
        tick(1);
        check("word0_count", 32'(out_count), 32'd4);
        check("word0_data",  out_data, 32'h1122_3344);
        check("word0_pc",    32'(out_pc), 32'h00);
        tick(3);
        check("full_no_req", 32'(mem_start), 32'd0);

        // take 1, 2, 1
        take = 1'b1; take_len = 3'd1;
        tick(1);
        check("take1_pc",   32'(out_pc), 32'h01);
        check("take1_data", out_data, 32'h2233_4455);
        check("take1_err",  32'(take_err), 32'd0);
        take_len = 3'd2;
        tick(1);
        check("take2_pc",   32'(out_pc), 32'h03);
        check("take2_data", out_data, 32'h4455_6677);
        take_len = 3'd1;
        tick(1);
        take = 1'b0;
        check("take3_pc",   32'(out_pc), 32'h04);
        check("take3_data", out_data, 32'h5566_7788);

        // Unaligned reset pc: leading bytes of the first word are dropped.
        pc_reset_value = 8'h02;
        enable         = 1'b0;
        pc_reset       = 1'b0;
        #1;
        check("rst2_out_pc",    32'(out_pc), 32'h02);
        check("rst2_out_count", 32'(out_count), 32'd0);
        tick(1);
        pc_reset = 1'b1;
        enable   = 1'b1;
        tick(1);
        check("unal_req_addr",  32'(mem_address), 32'h00);
        check("unal_req_start", 32'(mem_start), 32'd1);
        tick(1);
        check("unal_count", 32'(out_count), 32'd2);
        check("unal_data1", out_data, 32'h3344_0000);
        tick(2);
        check("unal_data2", out_data, 32'h3344_5566);
        check("unal_pc",    32'(out_pc), 32'h02);

        // Slow memory, redirect while the request is pending.
        mem_ready = 1'b0;
        take = 1'b1; take_len = 3'd4;
        tick(1);
        take = 1'b0;
        check("take4_pc", 32'(out_pc), 32'h06);
        tick(1);
        check("slow_req_start", 32'(mem_start), 32'd1);
        check("slow_req_addr",  32'(mem_address), 32'h02);
        redirect = 1'b1; redirect_pc = 8'h10;
        tick(1);
        redirect = 1'b0;
        check("disc_start", 32'(mem_start), 32'd1);
        check("disc_addr",  32'(mem_address), 32'h02);
        check("disc_count", 32'(out_count), 32'd0);
        check("disc_pc",    32'(out_pc), 32'h10);
        tick(1);
        check("disc_hold", 32'(mem_start), 32'd1);
        mem_ready = 1'b1;
        tick(1);
        check("disc_done_start", 32'(mem_start), 32'd0);
        check("disc_no_push",    32'(out_count), 32'd0);
        tick(1);
        check("redir_req_start", 32'(mem_start), 32'd1);
        check("redir_req_addr",  32'(mem_address), 32'h04);
        tick(1);
        check("redir_count", 32'(out_count), 32'd4);
        check("redir_data",  out_data, 32'hB5B4_B7B6);
        check("redir_pc",    32'(out_pc), 32'h10);

        // Redirect together with a bad take: redirect wins, no error.
        redirect = 1'b1; redirect_pc = 8'h12;
        take = 1'b1; take_len = 3'd7;
        tick(1);
        redirect = 1'b0;
        take     = 1'b0;
        enable   = 1'b0;
        check("rt_take_err", 32'(take_err), 32'd0);
        check("rt_pc",       32'(out_pc), 32'h12);
        check("rt_count",    32'(out_count), 32'd0);
        check("rt_start",    32'(mem_start), 32'd1);
        check("rt_addr",     32'(mem_address), 32'h04);
        tick(1);
        check("rt_fill_count", 32'(out_count), 32'd2);
        check("rt_fill_data",  out_data, 32'hB7B6_0000);

        // Invalid takes leave everything untouched.
        take = 1'b1; take_len = 3'd3;
        tick(1);
        take = 1'b0;
        check("over_err",   32'(take_err), 32'd1);
        check("over_count", 32'(out_count), 32'd2);
        check("over_pc",    32'(out_pc), 32'h12);
        check("over_data",  out_data, 32'hB7B6_0000);
        tick(1);
        check("err_pulse_end", 32'(take_err), 32'd0);
        take = 1'b1; take_len = 3'd0;
        tick(1);
        take = 1'b0;
        check("zero_len_err", 32'(take_err), 32'd1);
        take = 1'b1; take_len = 3'd2;
        tick(1);
        take = 1'b0;
        check("exact_err",   32'(take_err), 32'd0);
        check("exact_pc",    32'(out_pc), 32'h14);
        check("exact_count", 32'(out_count), 32'd0);
        check("exact_data",  out_data, 32'h0);

        // Wrap from the top of the address space.
        redirect = 1'b1; redirect_pc = 8'hFC; enable = 1'b1;
        tick(1);
        redirect = 1'b0;
        check("wrap_req_addr", 32'(mem_address), 32'h3F);
        check("wrap_req_pc",   32'(out_pc), 32'hFC);
        tick(1);
        check("wrap_data1",  out_data, 32'h5958_5B5A);
        check("wrap_pc1",    32'(out_pc), 32'hFC);
        check("wrap_count1", 32'(out_count), 32'd4);
        tick(1);
        check("wrap_next_start", 32'(mem_start), 32'd1);
        check("wrap_next_addr",  32'(mem_address), 32'h00);
        tick(1);
        take = 1'b1; take_len = 3'd4;
        tick(1);
        take = 1'b0;
        check("wrap_out_pc", 32'(out_pc), 32'h00);
        check("wrap_data2",  out_data, 32'h1122_3344);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
